// File: rtl/mac_pkg.sv
// Shared helpers for the MAC tree: ceiling log2 and the widths derived from it.
// Functions stand in for parameter-dependent localparams, since packages carry no parameters.
package mac_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int lvl_of(input int vec_len);
        return clog2(vec_len);
    endfunction

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int tree_w(input int data_w, input int vec_len);
        return prod_w(data_w) + lvl_of(vec_len);
    endfunction

    function automatic bit acc_w_ok(input int acc_w, input int data_w, input int vec_len);
        return acc_w >= tree_w(data_w, vec_len);
    endfunction

endpackage

// File: rtl/mac_adder_stage.sv
// One registered adder-tree level: PAIRS adjacent operand pairs summed one bit wider.
// Holds all state while en is low.
module mac_adder_stage
#(
    parameter int PAIRS  = 1,
    parameter int IN_W   = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [2*PAIRS*IN_W-1:0]      in_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [PAIRS*(IN_W+1)-1:0]    out_data
);
    import mac_pkg::*;

    localparam int OUT_W = IN_W + 1;

    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [PAIRS*OUT_W-1:0] sum_q, sum_d;
    logic [OUT_W-1:0]       lhs, rhs;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        sum_d   = sum_q;
        lhs     = '0;
        rhs     = '0;
        if (en) begin
            valid_d = in_valid;
            last_d  = in_last;
            for (int unsigned p = 0; p < PAIRS; p++) begin
                if (SIGNED) begin
                    lhs = OUT_W'($signed(in_data[2*p*IN_W +: IN_W]));
                    rhs = OUT_W'($signed(in_data[(2*p+1)*IN_W +: IN_W]));
                end else begin
                    lhs = OUT_W'(in_data[2*p*IN_W +: IN_W]);
                    rhs = OUT_W'(in_data[(2*p+1)*IN_W +: IN_W]);
                end
                sum_d[p*OUT_W +: OUT_W] = lhs + rhs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = sum_q;

endmodule

// File: rtl/mac_tree_stream.sv
// Streaming dot-product engine: multiply stage, LVL registered adder levels, then a
// group accumulator that emits one framed result per in_last beat.
module mac_tree_stream
#(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 16,
    parameter bit SIGNED  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W*VEC_LEN-1:0] in_a,
    input  logic [DATA_W*VEC_LEN-1:0] in_b,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic [CNT_W-1:0]          out_count
);
    import mac_pkg::*;

    localparam int LVL    = lvl_of(VEC_LEN);
    localparam int NLEAF  = 1 << LVL;
    localparam int PROD_W = prod_w(DATA_W);
    localparam int TREE_W = tree_w(DATA_W, VEC_LEN);

    if (!acc_w_ok(ACC_W, DATA_W, VEC_LEN)) begin : g_acc_w_check
        $error("mac_tree_stream: ACC_W narrower than 2*DATA_W+LVL");
    end

    logic                    en;
    logic                    m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [NLEAF*PROD_W-1:0] prod_q, prod_d;
    logic signed [PROD_W-1:0] op_a, op_b;
    logic                    lvl_valid [0:LVL];
    logic                    lvl_last  [0:LVL];
    logic [TREE_W-1:0]       tree_out;
    logic [ACC_W-1:0]        acc_q, acc_d, out_data_q, out_data_d, tree_ext, sum;
    logic [CNT_W-1:0]        cnt_q, cnt_d, out_count_q, out_count_d, cnt_inc;
    logic                    out_valid_q, out_valid_d;

    // A held result stalls the whole pipe, so in_ready follows out_ready combinationally.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    // Leaves at VEC_LEN and above stay zero so the tree needs no special padding.
    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        prod_d    = prod_q;
        op_a      = '0;
        op_b      = '0;
        if (en) begin
            m_valid_d = in_valid;
            m_last_d  = in_last;
            prod_d    = '0;
            for (int unsigned i = 0; i < VEC_LEN; i++) begin
                if (SIGNED) begin
                    op_a = PROD_W'($signed(in_a[i*DATA_W +: DATA_W]));
                    op_b = PROD_W'($signed(in_b[i*DATA_W +: DATA_W]));
                end else begin
                    op_a = PROD_W'(in_a[i*DATA_W +: DATA_W]);
                    op_b = PROD_W'(in_b[i*DATA_W +: DATA_W]);
                end
                prod_d[i*PROD_W +: PROD_W] = op_a * op_b;
            end
        end
    end

    assign lvl_valid[0] = m_valid_q;
    assign lvl_last[0]  = m_last_q;

    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int IN_W  = PROD_W + k - 1;
        localparam int PAIRS = NLEAF >> k;
        logic [2*PAIRS*IN_W-1:0]   din;
        logic [PAIRS*(IN_W+1)-1:0] dout;
        if (k == 1) begin : g_first
            assign din = prod_q;
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
        end
        mac_adder_stage #(
            .PAIRS (PAIRS),
            .IN_W  (IN_W),
            .SIGNED(SIGNED)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_valid (lvl_valid[k-1]),
            .in_last  (lvl_last[k-1]),
            .in_data  (din),
            .out_valid(lvl_valid[k]),
            .out_last (lvl_last[k]),
            .out_data (dout)
        );
    end

    if (LVL == 0) begin : g_no_tree
        assign tree_out = prod_q;
    end else begin : g_tree
        assign tree_out = g_lvl[LVL].dout;
    end

    always_comb begin
        if (SIGNED) tree_ext = ACC_W'($signed(tree_out));
        else        tree_ext = ACC_W'(tree_out);
        sum         = acc_q + tree_ext;
        cnt_inc     = cnt_q + 1'b1;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (en) begin
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
            if (lvl_valid[LVL]) begin
                if (lvl_last[LVL]) begin
                    out_data_d  = sum;
                    out_count_d = cnt_inc;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_mac_tree_stream.sv
// Directed bench for mac_tree_stream: signed 8-lane, unsigned 8-lane and signed 5-lane instances.
module tb_mac_tree_stream;

    logic clk;
    logic rst;

    logic        in_valid, in_last, in_ready, out_valid, out_ready;
    logic [63:0] in_a, in_b;
    logic [31:0] out_data;
    logic [15:0] out_count;

    logic        u_in_valid, u_in_last, u_in_ready, u_out_valid, u_out_ready;
    logic [63:0] u_in_a, u_in_b;
    logic [31:0] u_out_data;
    logic [15:0] u_out_count;

    logic        f_in_valid, f_in_last, f_in_ready, f_out_valid, f_out_ready;
    logic [39:0] f_in_a, f_in_b;
    logic [31:0] f_out_data;
    logic [15:0] f_out_count;

    int n_checks = 0;
    int n_pass   = 0;

    mac_tree_stream #(.DATA_W(8), .VEC_LEN(8), .ACC_W(32), .CNT_W(16), .SIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count)
    );

    mac_tree_stream #(.DATA_W(8), .VEC_LEN(8), .ACC_W(32), .CNT_W(16), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready), .in_a(u_in_a),
        .in_b(u_in_b), .in_last(u_in_last), .out_valid(u_out_valid), .out_ready(u_out_ready),
        .out_data(u_out_data), .out_count(u_out_count)
    );

    mac_tree_stream #(.DATA_W(8), .VEC_LEN(5), .ACC_W(32), .CNT_W(16), .SIGNED(1'b1)) u_dut_5 (
        .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_a(f_in_a),
        .in_b(f_in_b), .in_last(f_in_last), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_data(f_out_data), .out_count(f_out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One accepted beat on the main instance; called at a negedge, returns at the next one.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        in_a     = {8{a}};
        in_b     = {8{b}};
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_seen"}, out_valid, 1);
    endtask

    task automatic count_results(input int cycles, output int nres,
                                 output logic [31:0] rd, output logic [15:0] rc);
        nres = 0;
        rd   = '0;
        rc   = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) begin
                nres++;
                rd = out_data;
                rc = out_count;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int          nres;
        logic [31:0] rd;
        logic [15:0] rc;

        clk = 1'b0; rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        u_in_valid = 1'b0; u_in_last = 1'b0; u_in_a = '0; u_in_b = '0; u_out_ready = 1'b1;
        f_in_valid = 1'b0; f_in_last = 1'b0; f_in_a = '0; f_in_b = '0; f_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready", in_ready, 1);

        // Single beat: 8 * (2*3) = 48, visible after edge N+4.
        beat(8'd2, 8'd3, 1'b1);
        repeat (3) @(negedge clk);
        check("single_early", out_valid, 0);
        @(negedge clk);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 48);
        check("single_count", out_count, 1);
        @(negedge clk);
        check("single_clear", out_valid, 0);

        // Signed extremes: 8 * (-128*127) = -130048.
        beat(8'h80, 8'h7F, 1'b1);
        wait_result("sx");
        check("sx_data", $signed(out_data), -130048);
        check("sx_count", out_count, 1);
        @(negedge clk);

        // Unsigned extremes: 8 * 255*255 = 520200.
        u_in_a = {8{8'hFF}}; u_in_b = {8{8'hFF}}; u_in_last = 1'b1; u_in_valid = 1'b1;
        @(negedge clk);
        u_in_valid = 1'b0; u_in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("ux_early", u_out_valid, 0);
        @(negedge clk);
        check("ux_valid", u_out_valid, 1);
        check("ux_data", u_out_data, 520200);
        check("ux_count", u_out_count, 1);

        // Five lanes: 1+2+3+4+5 = 15, LVL=3 so also four edges.
        for (int i = 0; i < 5; i++) begin
            f_in_a[i*8 +: 8] = 8'(i + 1);
            f_in_b[i*8 +: 8] = 8'd1;
        end
        f_in_last = 1'b1; f_in_valid = 1'b1;
        @(negedge clk);
        f_in_valid = 1'b0; f_in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("v5_early", f_out_valid, 0);
        @(negedge clk);
        check("v5_valid", f_out_valid, 1);
        check("v5_data", f_out_data, 15);
        check("v5_count", f_out_count, 1);
        @(negedge clk);

        // Multi-beat group: 8 + 16 + 24 = 48 over 3 beats, then an empty-sum group.
        beat(8'd1, 8'd1, 1'b0);
        beat(8'd1, 8'd2, 1'b0);
        beat(8'd1, 8'd3, 1'b1);
        count_results(12, nres, rd, rc);
        check("multi_nres", nres, 1);
        check("multi_data", rd, 48);
        check("multi_count", rc, 3);
        beat(8'd0, 8'd0, 1'b1);
        wait_result("zero");
        check("zero_data", out_data, 0);
        check("zero_count", out_count, 1);
        @(negedge clk);

        // Backpressure: results 8 and 16 queued behind a held output.
        out_ready = 1'b0;
        beat(8'd1, 8'd1, 1'b1);
        beat(8'd2, 8'd1, 1'b1);
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_data", out_data, 8);
            @(negedge clk);
        end
        check("bp_first_valid", out_valid, 1);
        check("bp_first_data", out_data, 8);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_valid", out_valid, 1);
        check("bp_second_data", out_data, 16);
        check("bp_second_count", out_count, 1);
        @(negedge clk);
        check("bp_drained", out_valid, 0);

        // Reset mid-group: partial sum 16 / two beats must vanish.
        beat(8'd1, 8'd1, 1'b0);
        beat(8'd1, 8'd1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        beat(8'd1, 8'd1, 1'b1);
        count_results(12, nres, rd, rc);
        check("rstmid_nres", nres, 1);
        check("rstmid_data", rd, 8);
        check("rstmid_count", rc, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_tree_stream.md
# mac_tree_stream

Streaming, parametrised integer dot-product engine: each accepted beat carries two `VEC_LEN`-element vectors, multiplied element-wise and reduced through a fully registered adder tree. Tree results accumulate across beats until a beat flagged `in_last` closes the group, which emits one result. It is the next-generation vector-ALU MAC tree. It adds a valid/ready handshake with backpressure, group framing, signed/unsigned mode, non-power-of-two lengths and a beat counter.

## Interface
- `DATA_W`, 8: element width of A and B.
- `VEC_LEN`, 8: elements per vector, ≥1. Need not be a power of two.
- `ACC_W`, 32: accumulator and result width. Must satisfy ACC_W ≥ 2*DATA_W+LVL; elaboration fails otherwise.
- `CNT_W`, 16: beat-counter width.
- `SIGNED`, 1: 1 = two's-complement operands, 0 = unsigned.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: block can accept a beat.
- `in_a`, in, DATA_W*VEC_LEN: vector A. Element i occupies bits [i*DATA_W +: DATA_W].
- `in_b`, in, DATA_W*VEC_LEN: vector B, same packing as `in_a`.
- `in_last`, in, 1: this beat closes the current group.
- `out_valid`, out, 1: group result valid.
- `out_ready`, in, 1: consumer takes the result.
- `out_data`, out, ACC_W: group sum, two's complement if SIGNED=1.
- `out_count`, out, CNT_W: number of beats in the group.

## Operation
- LVL = clog2(VEC_LEN); LVL=0 when VEC_LEN=1. The tree has 2^LVL leaves; leaves at index VEC_LEN and above are tied to zero.
- A beat is accepted when `in_valid && in_ready` at a rising edge.
- Global advance enable: `en = !(out_valid && !out_ready)`. `in_ready = en`; this combinational path from `out_ready` is intentional.
- When `en` = 0, every pipeline register, valid bit and the accumulator hold.
- Stage M: products a_i*b_i, width 2*DATA_W, sign- or zero-extended per SIGNED, plus a valid bit and the last flag.
- Stage T1..T_LVL: each level adds pairs. Level k output width = 2*DATA_W+k. Each level carries valid and last.
- Stage O (accumulator), on a valid tree output:
  - sum = acc + sign/zero-extend(tree_out) mod 2^ACC_W; cnt = beat_cnt + 1.
  - If last: `out_data`←sum, `out_count`←cnt, `out_valid`←1, acc←0, beat_cnt←0.
  - Otherwise: acc←sum, beat_cnt←cnt.
- `out_valid` clears on the edge where `out_valid && out_ready`, unless a new last result loads on that same edge; that edge has `en`=1, so back-to-back results are possible.
- Overflow: accumulator wraps silently. `beat_cnt` wraps modulo 2^CNT_W.
- Invalid (bubble) beats do not touch acc or beat_cnt.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_count`=0.
  - acc=0, beat_cnt=0.
  - All stage valid bits 0.
  - `in_ready`=1 in the cycle after reset deasserts.
- Latency: a last beat accepted at edge N sets `out_valid` after edge N+LVL+1, with no stall. For VEC_LEN=8 this is 4 cycles.
- Throughput: one beat per cycle while `out_ready`=1.
- Stall: a stall freezes all stages for exactly the stalled cycles. Latency grows by the stall count; no beat is dropped or reordered.
- Reset mid-operation: all in-flight beats and the partial accumulation are discarded. The next accepted beat starts a new group.
- Reset has priority over acceptance and output handshake on the same edge.

## Structure
- Package `mac_pkg` holds:
  - the `clog2` function;
  - derived localparams LVL, PROD_W = 2*DATA_W, TREE_W = PROD_W+LVL, expressed as functions of parameters;
  - the ACC_W range check.
- Sub-module `mac_adder_stage` is one registered tree level. It is parametrised by pair count and input width, and takes `en`, `rst`, valid and last.
- The top instantiates LVL of these stages, plus the multiply stage and the accumulator/output stage inline.

## Test plan
- **Single-beat group.** VEC_LEN=8, DATA_W=8, SIGNED=1; all a=2, b=3, last=1 at edge N.
  - Required: `out_valid` after edge N+4, `out_data`=48, `out_count`=1.
- **Signed extremes.** All a=-128, b=127, last=1.
  - Required: `out_data`=-130048.
  - Repeat with SIGNED=0 and a=b=255: required `out_data`=520200.
- **Multi-beat group.** Three back-to-back beats, all-ones dot products 8, 16 and 24 (a=1, b=1/2/3), last on the third.
  - Required: exactly one result, 48, count 3.
  - A fourth beat with last=1 and a=b=0 must produce result 0, count 1.
- **Backpressure.** Two single-beat groups with sums 8 and 16 in flight; hold `out_ready`=0 for 5 cycles.
  - Required: `in_ready`=0 throughout; `out_data` stable at 8.
  - After release: 8, then 16 on consecutive handshakes.
- **Non-power-of-two.** VEC_LEN=5 instance, a=[1..5], b=1.
  - Required: result 15 after LVL+1=4 cycles; padded leaves contribute 0.
- **Reset mid-group.** Accept 2 non-last beats, pulse `rst`, then send one last beat with sum 8.
  - Required: result 8, count 1; no stale result emerges.
